// File: rtl/level_unshift_pkg.sv
// Shared types and constants for the float32 -> uint8 level-unshift datapath.
// Holds the float32 bit layout, lane classification and pixel range limits.
package level_unshift_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } float32_t;

  localparam int FP_BIAS      = 127;
  localparam int FRAC_W       = 23;
  localparam int PIXEL_OFFSET = 128;
  localparam int PIXEL_MAX    = 255;
  // Biased exponent from which |x| >= 512: always saturates, so no shift is attempted.
  localparam int SAT_EXP      = FP_BIAS + 9;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_NAN,
    CLS_PINF,
    CLS_NINF
  } fp_class_e;

  function automatic fp_class_e classify(input float32_t f);
    fp_class_e c;
    if (f.exp == 8'd0)
      c = CLS_ZERO;
    else if (f.exp == 8'hFF)
      c = (f.frac != '0) ? CLS_NAN : (f.sign ? CLS_NINF : CLS_PINF);
    else
      c = CLS_NORM;
    return c;
  endfunction

endpackage

// File: rtl/level_unshift_if.sv
// Row handshake bundle: float32 rows in, uint8 pixel rows out, valid/ready on both sides.
// The slave modport is the level_unshift side; master is the producer/consumer side.
interface level_unshift_if #(parameter int LANES = 8);

  logic [32*LANES-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic [8*LANES-1:0]  dout;
  logic                dout_valid;
  logic                dout_ready;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

endinterface

// File: rtl/level_unshift_float_to_uint8.sv
// One lane: float32 -> clamp(round_half_even(x) + 128, 0, 255); 3 cycles, all stages gated by i_en.
// Stalls by holding every register while i_en is low; o_clamped exists only with LEVEL_UNSHIFT_SAT_CNT_EN.
module float_to_uint8
  import level_unshift_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_en,
  input  float32_t   i_din,
  output logic [7:0] o_pix
`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  ,
  output logic       o_clamped
`endif
);

  // Stage 1: unpack and classify.
  fp_class_e   r1_cls;
  logic        r1_sign;
  logic [7:0]  r1_exp;
  logic [23:0] r1_mant;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r1_cls  <= CLS_ZERO;
      r1_sign <= 1'b0;
      r1_exp  <= '0;
      r1_mant <= '0;
    end else if (i_en) begin
      r1_cls  <= classify(i_din);
      r1_sign <= i_din.sign;
      r1_exp  <= i_din.exp;
      r1_mant <= {1'b1, i_din.frac};
    end
  end

  // Stage 2: align to integer and round half to even; infinities become +/-512.
  logic [7:0]         w_sh;
  logic [47:0]        w_wide;
  logic               w_round_up;
  logic [23:0]        w_mag24;
  logic [9:0]         w_mag;
  logic signed [10:0] w_val;
  logic signed [10:0] r2_val;

  always_comb begin
    w_sh       = 8'(FP_BIAS + FRAC_W) - r1_exp;
    w_wide     = {r1_mant, 24'd0} >> w_sh;
    w_round_up = w_wide[23] && ((|w_wide[22:0]) || w_wide[24]);
    w_mag24    = w_wide[47:24] + 24'(w_round_up);
    if ((r1_exp >= 8'(SAT_EXP)) || (w_mag24 > 24'd511))
      w_mag = 10'd512;
    else
      w_mag = w_mag24[9:0];
    unique case (r1_cls)
      CLS_NORM: w_val = r1_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
      CLS_PINF: w_val = 11'sd512;
      CLS_NINF: w_val = -11'sd512;
      default:  w_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r2_val <= '0;
    else if (i_en)
      r2_val <= w_val;
  end

  // Stage 3: offset and saturate.
  logic signed [11:0] w_sum;
  logic               w_lo;
  logic               w_hi;
  logic [7:0]         w_pix;
  logic [7:0]         r3_pix;

  assign w_sum = $signed({r2_val[10], r2_val}) + $signed(12'(PIXEL_OFFSET));
  assign w_lo  = (w_sum < 0);
  assign w_hi  = (w_sum > $signed(12'(PIXEL_MAX)));
  assign w_pix = w_lo ? 8'd0 : (w_hi ? 8'(PIXEL_MAX) : w_sum[7:0]);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r3_pix <= '0;
    else if (i_en)
      r3_pix <= w_pix;
  end

  assign o_pix = r3_pix;

`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  logic r3_clamped;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r3_clamped <= 1'b0;
    else if (i_en)
      r3_clamped <= w_lo | w_hi;
  end

  assign o_clamped = r3_clamped;
`endif

endmodule

// File: rtl/level_unshift.sv
// Level unshift of LANES float32 samples to uint8 pixels; fixed 3-cycle latency, one row per cycle.
// Whole pipe stalls when the output row is not taken; LEVEL_UNSHIFT_SAT_CNT_EN adds sat_count.
module level_unshift
  import level_unshift_pkg::*;
#(
  parameter int  LANES = 8,
  localparam int PIPE  = 3
) (
  input  logic                clk,
  input  logic                nrst,
  level_unshift_if.slave      bus
`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  logic [PIPE-1:0]      r_vld;
  logic                 w_advance;
  logic [8*LANES-1:0]   w_dout;

  // Any empty output slot or a taking consumer lets every stage move together.
  assign w_advance      = !r_vld[PIPE-1] || bus.dout_ready;
  assign bus.din_ready  = w_advance;
  assign bus.dout_valid = r_vld[PIPE-1];
  assign bus.dout       = w_dout;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_vld <= '0;
    else if (w_advance)
      r_vld <= {r_vld[PIPE-2:0], bus.din_valid};
  end

`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  logic [LANES-1:0] w_clamped;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    float_to_uint8 u_f2u (
      .clk       (clk),
      .nrst      (nrst),
      .i_en      (w_advance),
      .i_din     (bus.din[32*l +: 32]),
      .o_pix     (w_dout[8*l +: 8])
`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
      ,
      .o_clamped (w_clamped[l])
`endif
    );
  end

`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] w_n_clamp;
  logic [16:0]      w_sat_sum;
  logic [15:0]      r_sat_count;

  always_comb begin
    w_n_clamp = '0;
    for (int l = 0; l < LANES; l++)
      w_n_clamp = w_n_clamp + CNT_W'(w_clamped[l]);
  end

  assign w_sat_sum = 17'(r_sat_count) + 17'(w_n_clamp);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_sat_count <= '0;
    else if (r_vld[PIPE-1] && bus.dout_ready)
      r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
  end

  assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_level_unshift.sv
// Bench for level_unshift: scoreboard of expected rows, checked when the DUT transfers a row.
// Build with LEVEL_UNSHIFT_SAT_CNT_EN defined to also exercise sat_count.
module tb_level_unshift;

  localparam int LANES = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  level_unshift_if #(.LANES(LANES)) bus ();

`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  level_unshift #(.LANES(LANES)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus)
`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8*LANES-1:0] pix;
    int                 nclamp;
    int                 acc;
    bit                 lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   exp_sat  = 0;
  int   last_acc = 0;
  bit   lat_chk  = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: real-valued rounding, not the bit-level datapath.
  function automatic void model_lane(input logic [31:0] f, output logic [7:0] px, output int clamp);
    int  e, r, t;
    real v, fl, d;
    e     = int'(f[30:23]);
    clamp = 0;
    px    = 8'd128;
    if (e == 255) begin
      if (f[22:0] == 23'd0) begin
        px    = f[31] ? 8'd0 : 8'd255;
        clamp = 1;
      end
      return;
    end
    if (e == 0) return;
    if (e >= 140) begin
      r = 100000;
    end else begin
      v  = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      fl = $floor(v);
      d  = v - fl;
      r  = int'(fl);
      if (d > 0.5 || (d == 0.5 && (r % 2) == 1)) r++;
    end
    if (f[31]) r = -r;
    t = r + 128;
    if (t < 0) begin
      px = 8'd0; clamp = 1;
    end else if (t > 255) begin
      px = 8'd255; clamp = 1;
    end else begin
      px = 8'(t);
    end
  endfunction

  function automatic logic [31:0] rand_lane();
    int          k;
    logic [31:0] v;
    k = $urandom_range(0, 9);
    if (k == 0) begin
      case ($urandom_range(0, 5))
        0:       v = 32'h0000_0000;
        1:       v = 32'h8000_0000;
        2:       v = 32'h7F80_0000;
        3:       v = 32'hFF80_0000;
        4:       v = 32'h7FC0_0001;
        default: v = 32'h0001_2345;
      endcase
    end else begin
      v = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 140)), 23'($urandom)};
      if (k < 4) v[15:0] = 16'd0;
    end
    return v;
  endfunction

  task automatic send_row(input logic [32*LANES-1:0] row, input logic [8*LANES-1:0] pix,
                          input int nclamp, input bit b2b);
    exp_t e;
    int   waited;
    waited     = 0;
    e.pix      = pix;
    e.nclamp   = nclamp;
    e.lat      = lat_chk;
    bus.din       = row;
    bus.din_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (b2b && waited == 0) check_eq("b2b_din_ready", bus.din_ready, 1);
      if (bus.din_ready === 1'b1) break;
      waited++;
      if (waited > 200) begin
        check_eq("din_ready_timeout", bus.din_ready, 1);
        bus.din_valid = 1'b0;
        return;
      end
    end
    e.acc = cyc + 1;
    if (b2b) check_eq("b2b_accept_gap", e.acc - last_acc, 1);
    last_acc = e.acc;
    sb.push_back(e);
    n_in++;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic send_rand(input bit b2b);
    logic [32*LANES-1:0] row;
    logic [8*LANES-1:0]  pix;
    logic [7:0]          px;
    int                  c, nc;
    nc = 0;
    for (int l = 0; l < LANES; l++) begin
      row[32*l +: 32] = rand_lane();
      model_lane(row[32*l +: 32], px, c);
      pix[8*l +: 8] = px;
      nc += c;
    end
    send_row(row, pix, nc, b2b);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nrst && bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        check_eq("extra_row", n_out + 1, n_in);
      end else begin
        e = sb.pop_front();
        check_eq("dout", bus.dout, e.pix);
        if (e.lat) check_eq("latency", cyc + 1 - e.acc, 3);
        exp_sat = (exp_sat + e.nclamp > 65535) ? 65535 : exp_sat + e.nclamp;
      end
      n_out++;
    end
  end

  logic [31:0] dir_in  [9] = '{32'h0000_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'hBF00_0000,
                               32'hC300_0000, 32'h4348_0000, 32'h42FE_0000, 32'h7F80_0000,
                               32'h7FC0_0000};
  logic [7:0]  dir_out [9] = '{8'd128, 8'd128, 8'd130, 8'd128, 8'd0, 8'd255, 8'd255, 8'd255, 8'd128};
  int          dir_cl  [9] = '{0, 0, 0, 0, 0, 8, 0, 8, 0};

  initial begin
    int                 base;
    logic [31:0]        lv;
    logic [7:0]         pv;
    logic [8*LANES-1:0] held;

    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_dout_valid", bus.dout_valid, 0);
    check_eq("rst_dout", bus.dout, 0);
    check_eq("rst_din_ready", bus.din_ready, 1);
`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
    check_eq("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    check_eq("din_ready_after_rst", bus.din_ready, 1);
    @(posedge clk);
    #1;

    // Directed single-value rows, every lane identical.
    for (int i = 0; i < 9; i++) begin
      lv = dir_in[i];
      pv = dir_out[i];
      send_row({LANES{lv}}, {LANES{pv}}, dir_cl[i], 1'b0);
    end
    // Mixed-lane rows: ties, denormal, -0, saturation edges.
    send_row({32'h8000_0000, 32'h0000_0001, 32'hC020_0000, 32'h4020_0000,
              32'hBF00_0000, 32'h3FC0_0000, 32'h3F00_0000, 32'h0000_0000},
             {8'd128, 8'd128, 8'd126, 8'd130, 8'd128, 8'd130, 8'd128, 8'd128}, 0, 1'b0);
    send_row({32'h3F40_0000, 32'hC301_0000, 32'hC2FF_0000, 32'h42FD_0000,
              32'h42FF_0000, 32'h4300_0000, 32'h7F7F_FFFF, 32'hFF80_0000},
             {8'd129, 8'd0, 8'd0, 8'd254, 8'd255, 8'd255, 8'd255, 8'd0}, 5, 1'b0);
    for (int i = 0; i < 30; i++) send_rand(1'b0);
    wait_drain();

    // Back-to-back rows.
    base = n_out;
    for (int i = 0; i < 20; i++) send_rand(i > 0);
    wait_drain();
    check_eq("b2b_count", n_out - base, 20);

    // Output stall with the pipe full.
    lat_chk        = 1'b0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    bus.din       = {LANES{32'h3FC0_0000}};
    bus.din_valid = 1'b1;
    held          = sb[0].pix;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_din_ready", bus.din_ready, 0);
      check_eq("stall_dout_valid", bus.dout_valid, 1);
      check_eq("stall_dout", bus.dout, held);
    end
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    send_rand(1'b0);
    wait_drain();
    check_eq("stall_in_out_count", n_out, n_in);

    // Reset with two rows in flight.
    lat_chk = 1'b1;
    send_rand(1'b0);
    send_rand(1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("midrst_dout_valid", bus.dout_valid, 0);
    check_eq("midrst_dout", bus.dout, 0);
    check_eq("midrst_din_ready", bus.din_ready, 1);
    sb.delete();
    n_in    = n_in - 2;
    exp_sat = 0;
    base    = n_out;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("no_ghost_rows", n_out, base);
    @(posedge clk);
    #1;
    send_row({LANES{32'hC020_0000}}, {LANES{8'd126}}, 0, 1'b0);
    wait_drain();

`ifdef LEVEL_UNSHIFT_SAT_CNT_EN
    for (int i = 0; i < 3; i++)
      send_row({{6{32'h0000_0000}}, 32'hFF80_0000, 32'h4348_0000},
               {{6{8'd128}}, 8'd0, 8'd255}, 2, 1'b0);
    wait_drain();
    check_eq("sat_count_6", sat_count, 6);
    for (int i = 0; i < 8200; i++)
      send_row({LANES{32'h7F80_0000}}, {LANES{8'd255}}, 8, i > 0);
    wait_drain();
    check_eq("sat_count_model", sat_count, exp_sat);
    check_eq("sat_count_max", sat_count, 16'hFFFF);
    send_row({LANES{32'hFF80_0000}}, {LANES{8'd0}}, 8, 1'b0);
    wait_drain();
    check_eq("sat_count_hold", sat_count, 16'hFFFF);
`endif

    check_eq("sb_residual", sb.size(), 0);
    check_eq("rows_in_out", n_out, n_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d rows out", n_out, n_in);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/level_unshift.md
LEVEL_UNSHIFT -- requirements
Module: level_unshift

Interface
REQ-001 SHALL have parameter LANES, default 8: number of parallel sample lanes.
REQ-002 SHALL have parameter PIPE, fixed at 3: pipeline depth in cycles (documentation only; not overridable).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  32 x LANES  IEEE-754 single-precision samples (IDCT output).
REQ-006 SHALL have port din_valid  input  1  din holds a valid row.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port dout  output  8 x LANES  unsigned pixels.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid row.
REQ-010 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.

Function
REQ-011 SHALL compute per lane: dout = clamp(round(din) + 128, 0, 255).
REQ-012 SHALL use round-to-nearest, ties-to-even (0.5 -> 0, 1.5 -> 2, -2.5 -> -2).
REQ-013 SHALL flush denormals and +/-0 to 0, so the lane output is 128.
REQ-014 SHALL output 128 for NaN, 255 for +Inf and 0 for -Inf.
REQ-015 SHALL clamp any magnitude with exponent >= 2^8 without overflowing the internal shift; use an internal integer of at least 10 signed bits.
REQ-016 SHALL pipeline as stage 1 unpack/classify, stage 2 align/round, stage 3 add 128 and saturate; row latency is exactly 3 cycles when unstalled.
REQ-017 SHALL advance all stages together when advance = !dout_valid || dout_ready, and hold every stage register when advance is low.
REQ-018 SHALL drive din_ready = advance combinationally; a row transfers on din_valid && din_ready.
REQ-019 SHALL hold dout and dout_valid stable while dout_valid && !dout_ready.
REQ-020 SHALL propagate a single valid bit per stage; bubbles are not compressed, and lanes share one valid bit.
REQ-021 SHALL sustain one row per cycle when dout_ready is held high.

Reset
REQ-022 SHALL, on nrst low, asynchronously clear all stage valid bits; dout_valid = 0 and dout = 0 on every lane.
REQ-023 SHALL discard rows in flight when reset asserts mid-operation; the first accepted row after release exits after 3 cycles.
REQ-024 SHALL drive din_ready = 1 during reset and on the first cycle after reset.

Configuration
REQ-025 SHALL, when macro LEVEL_UNSHIFT_SAT_CNT_EN is defined, add output sat_count (16 bits, reset 0) that increments by the number of lanes clamped (pre-clamp value < 0 or > 255, including Inf) on each dout transfer, saturating at 0xFFFF.
REQ-026 SHALL, without LEVEL_UNSHIFT_SAT_CNT_EN, have no sat_count port and no counter logic.

Structure
REQ-027 SHALL place in a shared package: float32 struct typedef (sign, exp[7:0], frac[22:0]), FP_BIAS = 127, PIXEL_OFFSET = 128, PIXEL_MAX = 255.
REQ-028 SHALL instantiate one sub-module float_to_uint8 per lane (stages 1-3, enable input = advance); the top holds the valid chain and handshake.

Verification
REQ-029 SHALL test: all lanes 0x00000000, 0x3F000000 (0.5), 0x3FC00000 (1.5), 0xBF000000 (-0.5) -> 128, 128, 130, 128 after exactly 3 cycles.
REQ-030 SHALL test: 0xC3000000 (-128.0), 0x43480000 (200.0), 0x42FE0000 (127.0), 0x7F800000 (+Inf), 0x7FC00000 (NaN) -> 0, 255, 255, 255, 128.
REQ-031 SHALL test: 20 back-to-back rows with dout_ready = 1 -> 20 outputs on consecutive cycles, in order, din_ready always 1.
REQ-032 SHALL test: dout_ready low for 5 cycles with a valid output pending -> din_ready = 0, dout stable, no row lost or duplicated after release.
REQ-033 SHALL test: nrst pulsed low with 2 rows in flight -> dout_valid = 0 immediately, and neither row appears after release.
REQ-034 SHALL test (SAT_CNT_EN build): 3 rows each with 2 out-of-range lanes -> sat_count = 6; after 0xFFFF, sat_count stays 0xFFFF.
